// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared state type, ILI9341 command codes and link word encoders
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_ISSUE,
        HDR_WAIT,
        PIX_ISSUE,
        PIX_WAIT,
        RELEASE,
        DONE
    } fill_state_t;

    localparam logic [7:0]  CASET        = 8'h2A;
    localparam logic [7:0]  PASET        = 8'h2B;
    localparam logic [7:0]  RAMWR        = 8'h2C;
    localparam logic [3:0]  HDR_LAST     = 4'd10;
    // CSX high with DCX high: deselects the panel after the last pixel
    localparam logic [15:0] RELEASE_WORD = 16'h0300;

    // Byte-port word with DCX low (command)
    function automatic logic [15:0] cmd_word(input logic [7:0] b);
        return {6'b0, 1'b0, 1'b0, b};
    endfunction

    // Byte-port word with DCX high (parameter data)
    function automatic logic [15:0] data_word(input logic [7:0] b);
        return {6'b0, 1'b1, 1'b0, b};
    endfunction

endpackage

// File: rtl/lcd_hdr_rom.sv
// rtl/lcd_hdr_rom.sv - maps header step and window bounds to the byte-port word
module lcd_hdr_rom (
    input  logic [3:0]  step,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    output logic [15:0] lcd_in
);
    import lcd_pkg::*;

    // Coordinates are 9 bits, sent as 16-bit big-endian, so the high byte is just bit 8
    always_comb begin
        lcd_in = cmd_word(RAMWR);
        case (step)
            4'd0:    lcd_in = cmd_word(CASET);
            4'd1:    lcd_in = data_word({7'b0, x0[8]});
            4'd2:    lcd_in = data_word(x0[7:0]);
            4'd3:    lcd_in = data_word({7'b0, x1[8]});
            4'd4:    lcd_in = data_word(x1[7:0]);
            4'd5:    lcd_in = cmd_word(PASET);
            4'd6:    lcd_in = data_word({7'b0, y0[8]});
            4'd7:    lcd_in = data_word(y0[7:0]);
            4'd8:    lcd_in = data_word({7'b0, y1[8]});
            4'd9:    lcd_in = data_word(y1[7:0]);
            default: lcd_in = cmd_word(RAMWR);
        endcase
    end

endmodule

// File: rtl/lcd_fill_ctrl.sv
// rtl/lcd_fill_ctrl.sv - solid-colour window fill sequencer for the ILI9341 SPI link
module lcd_fill_ctrl #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [8:0]  x0,
    input  logic [8:0]  x1,
    input  logic [8:0]  y0,
    input  logic [8:0]  y1,
    input  logic [15:0] color,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [15:0] lcd_status,
    output logic        lcd_load,
    output logic        lcd_load16,
    output logic [15:0] lcd_in
);
    import lcd_pkg::*;

    localparam logic [9:0] WIDTH_L  = 10'(WIDTH);
    localparam logic [9:0] HEIGHT_L = 10'(HEIGHT);

    fill_state_t state;
    logic [3:0]  step;
    logic [16:0] count;
    logic [8:0]  x0_q, x1_q, y0_q, y1_q;
    logic [15:0] color_q;

    logic        link_busy;
    logic        bounds_ok;
    logic [16:0] span_x, span_y, npix;
    logic [3:0]  rom_step;
    logic [15:0] rom_word;
    logic        unused_status;

    assign link_busy     = lcd_status[15];
    assign unused_status = ^lcd_status[14:0];

    assign bounds_ok = (x0 <= x1) && ({1'b0, x1} < WIDTH_L) &&
                       (y0 <= y1) && ({1'b0, y1} < HEIGHT_L);
    assign span_x    = {8'b0, x1 - x0} + 17'd1;
    assign span_y    = {8'b0, y1 - y0} + 17'd1;
    assign npix      = span_x * span_y;

    // The ROM is addressed with the step about to be issued so its word can be registered with the strobe
    assign rom_step = (state == IDLE) ? 4'd0 : step + 4'd1;

    lcd_hdr_rom u_hdr_rom (
        .step   (rom_step),
        .x0     (x0_q),
        .x1     (x1_q),
        .y0     (y0_q),
        .y1     (y1_q),
        .lcd_in (rom_word)
    );

    // Fill sequencer: strobes are registered on the transition into each ISSUE/RELEASE state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            step       <= 4'd0;
            count      <= 17'd0;
            x0_q       <= 9'd0;
            x1_q       <= 9'd0;
            y0_q       <= 9'd0;
            y1_q       <= 9'd0;
            color_q    <= 16'h0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            lcd_load   <= 1'b0;
            lcd_load16 <= 1'b0;
            lcd_in     <= 16'h0000;
        end else begin
            lcd_load   <= 1'b0;
            lcd_load16 <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (bounds_ok) begin
                            x0_q     <= x0;
                            x1_q     <= x1;
                            y0_q     <= y0;
                            y1_q     <= y1;
                            color_q  <= color;
                            step     <= 4'd0;
                            count    <= npix;
                            busy     <= 1'b1;
                            lcd_load <= 1'b1;
                            lcd_in   <= rom_word;
                            state    <= HDR_ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                HDR_ISSUE: state <= HDR_WAIT;
                HDR_WAIT: begin
                    if (!link_busy) begin
                        if (step == HDR_LAST) begin
                            lcd_load16 <= 1'b1;
                            lcd_in     <= color_q;
                            state      <= PIX_ISSUE;
                        end else begin
                            step     <= step + 4'd1;
                            lcd_load <= 1'b1;
                            lcd_in   <= rom_word;
                            state    <= HDR_ISSUE;
                        end
                    end
                end
                PIX_ISSUE: state <= PIX_WAIT;
                PIX_WAIT: begin
                    if (!link_busy) begin
                        count <= count - 17'd1;
                        if (count == 17'd1) begin
                            lcd_load <= 1'b1;
                            lcd_in   <= RELEASE_WORD;
                            state    <= RELEASE;
                        end else begin
                            lcd_load16 <= 1'b1;
                            lcd_in     <= color_q;
                            state      <= PIX_ISSUE;
                        end
                    end
                end
                RELEASE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_fill_ctrl.sv
// tb/tb_lcd_fill_ctrl.sv - table-driven bench for lcd_fill_ctrl with a behavioural link model
module tb_lcd_fill_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [8:0]  x0, x1, y0, y1;
    logic [15:0] color;
    logic        busy, done, err;
    logic [15:0] lcd_status;
    logic        lcd_load, lcd_load16;
    logic [15:0] lcd_in;

    lcd_fill_ctrl #(.WIDTH(240), .HEIGHT(320)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .color      (color),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .lcd_status (lcd_status),
        .lcd_load   (lcd_load),
        .lcd_load16 (lcd_load16),
        .lcd_in     (lcd_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  x0, x1, y0, y1;
        logic [15:0] color;
        bit          exp_err;
        int          exp_npix;
        int          exp_done;
    } vec_t;

    localparam int NV = 7;
    vec_t        vecs    [NV];
    logic [15:0] exp_hdr [NV][11];

    int n_chk  = 0;
    int n_fail = 0;

    // Link model: busy from the cycle after a strobe for 16 (byte) or 32 (word) cycles; no reset
    int link_rem   = 0;
    int byte_cnt   = 0;
    int stretch_at = -1;
    bit fast_link  = 1'b0;

    always @(posedge clk) begin
        if (lcd_load || lcd_load16) begin
            if (fast_link)
                link_rem <= 0;
            else if (lcd_load)
                link_rem <= (byte_cnt == stretch_at) ? 26 : 16;
            else
                link_rem <= 32;
            if (lcd_load) byte_cnt <= byte_cnt + 1;
        end else if (link_rem > 0) begin
            link_rem <= link_rem - 1;
        end
    end

    assign lcd_status = {(link_rem != 0), 15'h0000};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_outputs_zero(input string p);
        chk({p, "_busy"},   {31'b0, busy},       32'd0);
        chk({p, "_done"},   {31'b0, done},       32'd0);
        chk({p, "_err"},    {31'b0, err},        32'd0);
        chk({p, "_load"},   {31'b0, lcd_load},   32'd0);
        chk({p, "_load16"}, {31'b0, lcd_load16}, 32'd0);
        chk({p, "_in"},     {16'b0, lcd_in},     32'd0);
    endtask

    task automatic run_vec(input int vi, input int second_at, input logic [15:0] color2,
                           input int max_cyc, input bit partial, input int partial_npix,
                           input int shift);
        int    hdr_idx     = 0;
        int    npix        = 0;
        int    n_done      = 0;
        int    n_errp      = 0;
        int    rel_release = -1;
        int    rel_done    = -1;
        int    rel_err     = -1;
        int    rel_first   = -1;
        int    bad_color   = 0;
        int    both        = 0;
        int    strobe_busy = 0;
        int    n_release   = 0;
        int    busy_seen   = 0;
        string tag;
        tag   = $sformatf("v%0d", vi);
        x0    = vecs[vi].x0;
        x1    = vecs[vi].x1;
        y0    = vecs[vi].y0;
        y1    = vecs[vi].y1;
        color = vecs[vi].color;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy_c1"}, {31'b0, busy}, {31'b0, !vecs[vi].exp_err});
        for (int rel = 1; rel <= max_cyc; rel++) begin
            if (rel > 1) @(negedge clk);
            start = (second_at > 0) && (rel == second_at);
            if ((second_at > 0) && (rel == second_at)) color = color2;
            if (lcd_load && lcd_load16) both++;
            if ((lcd_load || lcd_load16) && lcd_status[15]) strobe_busy++;
            if ((lcd_load || lcd_load16) && rel_first < 0) rel_first = rel;
            if (lcd_load) begin
                if (hdr_idx < 11) begin
                    chk($sformatf("%s_hdr%0d", tag, hdr_idx), {16'b0, lcd_in}, {16'b0, exp_hdr[vi][hdr_idx]});
                    hdr_idx++;
                end else begin
                    chk({tag, "_release_word"}, {16'b0, lcd_in}, 32'h0300);
                    n_release++;
                    rel_release = rel;
                end
            end
            if (lcd_load16) begin
                npix++;
                if (lcd_in !== vecs[vi].color) bad_color++;
            end
            if (busy) busy_seen++;
            if (done) begin
                n_done++;
                if (rel_done < 0) rel_done = rel;
            end
            if (err) begin
                n_errp++;
                if (rel_err < 0) rel_err = rel;
            end
        end
        start = 1'b0;
        chk({tag, "_both_strobes"}, both, 0);
        chk({tag, "_strobe_while_busy"}, strobe_busy, 0);
        if (vecs[vi].exp_err) begin
            chk({tag, "_err_cycle"}, rel_err, 1);
            chk({tag, "_err_pulses"}, n_errp, 1);
            chk({tag, "_strobes"}, hdr_idx + npix + n_release, 0);
            chk({tag, "_busy_cycles"}, busy_seen, 0);
        end else begin
            chk({tag, "_first_strobe"}, rel_first, 1);
            chk({tag, "_hdr_count"}, hdr_idx, 11);
            chk({tag, "_bad_color"}, bad_color, 0);
            chk({tag, "_err_pulses"}, n_errp, 0);
            if (partial) begin
                chk({tag, "_pix_so_far"}, npix, partial_npix);
                chk({tag, "_still_busy"}, {31'b0, busy}, 32'd1);
            end else begin
                chk({tag, "_pix_count"}, npix, vecs[vi].exp_npix);
                chk({tag, "_release_count"}, n_release, 1);
                chk({tag, "_release_cycle"}, rel_release, vecs[vi].exp_done - 1 + shift);
                chk({tag, "_done_cycle"}, rel_done, vecs[vi].exp_done + shift);
                chk({tag, "_done_pulses"}, n_done, 1);
                chk({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
            end
        end
    endtask

    initial begin
        vecs[0] = '{9'd5,   9'd5,   9'd7,   9'd7,   16'hF800, 1'b0, 1,     234};
        vecs[1] = '{9'd10,  9'd9,   9'd0,   9'd0,   16'h1234, 1'b1, 0,     0};
        vecs[2] = '{9'd0,   9'd240, 9'd0,   9'd0,   16'h1234, 1'b1, 0,     0};
        vecs[3] = '{9'd0,   9'd0,   9'd0,   9'd320, 16'h1234, 1'b1, 0,     0};
        vecs[4] = '{9'd2,   9'd4,   9'd1,   9'd2,   16'h07E0, 1'b0, 6,     404};
        vecs[5] = '{9'd0,   9'd239, 9'd318, 9'd319, 16'h001F, 1'b0, 480,   16520};
        vecs[6] = '{9'd0,   9'd239, 9'd0,   9'd319, 16'h5A5A, 1'b0, 76800, 0};
        exp_hdr[0] = '{16'h002A, 16'h0200, 16'h0205, 16'h0200, 16'h0205, 16'h002B,
                       16'h0200, 16'h0207, 16'h0200, 16'h0207, 16'h002C};
        exp_hdr[1] = '{default: 16'h0000};
        exp_hdr[2] = '{default: 16'h0000};
        exp_hdr[3] = '{default: 16'h0000};
        exp_hdr[4] = '{16'h002A, 16'h0200, 16'h0202, 16'h0200, 16'h0204, 16'h002B,
                       16'h0200, 16'h0201, 16'h0200, 16'h0202, 16'h002C};
        exp_hdr[5] = '{16'h002A, 16'h0200, 16'h0200, 16'h0200, 16'h02EF, 16'h002B,
                       16'h0201, 16'h023E, 16'h0201, 16'h023F, 16'h002C};
        exp_hdr[6] = '{16'h002A, 16'h0200, 16'h0200, 16'h0200, 16'h02EF, 16'h002B,
                       16'h0200, 16'h0200, 16'h0201, 16'h023F, 16'h002C};

        resetn = 1'b0;
        start  = 1'b0;
        x0     = 9'd0;
        x1     = 9'd0;
        y0     = 9'd0;
        y1     = 9'd0;
        color  = 16'h0000;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_vec(i, 0, 16'h0000, vecs[i].exp_err ? 30 : vecs[i].exp_done + 3, 1'b0, 0, 0);
            repeat (40) @(negedge clk);
        end

        // Second start at cycle 50 with another colour must be dropped silently
        run_vec(4, 50, 16'hFFFF, vecs[4].exp_done + 3, 1'b0, 0, 0);
        repeat (40) @(negedge clk);

        // Link held busy 10 extra cycles after header byte 3
        stretch_at = byte_cnt + 3;
        run_vec(0, 0, 16'h0000, vecs[0].exp_done + 13, 1'b0, 0, 10);
        stretch_at = -1;
        repeat (40) @(negedge clk);

        // Full-screen window on an instant link: header and first pixels, then abort by reset
        fast_link = 1'b1;
        repeat (5) @(negedge clk);
        run_vec(6, 0, 16'h0000, 400, 1'b1, 189, 0);
        #2 resetn = 1'b0;
        #1 chk_outputs_zero("fs_async_rst");
        repeat (2) @(negedge clk);
        resetn    = 1'b1;
        fast_link = 1'b0;
        repeat (5) @(negedge clk);

        // 4x4 fill, reset asserted between clock edges while in PIX_WAIT
        x0    = 9'd0;
        x1    = 9'd3;
        y0    = 9'd0;
        y1    = 9'd3;
        color = 16'hAAAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (242) @(negedge clk);
        chk("r4_busy", {31'b0, busy}, 32'd1);
        chk("r4_in", {16'b0, lcd_in}, 32'h0000AAAA);
        chk("r4_load16", {31'b0, lcd_load16}, 32'd0);
        #2 resetn = 1'b0;
        #1 chk_outputs_zero("r4_async_rst");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        run_vec(0, 0, 16'h0000, vecs[0].exp_done + 3, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_fill_ctrl.md
# lcd_fill_ctrl

Sequencer for the ILI9341 SPI link block: on a `start` pulse it fills a rectangular window with a solid RGB565 colour. It issues CASET/PASET/RAMWR commands plus address bytes through the link's byte port, then streams 16-bit pixel words through its word port, then releases CSX. It sits between the CPU-side MMIO register file and the SPI link block, and owns that block's `load`/`load16`/`in` inputs exclusively.

## Interface
- `WIDTH`, 240: panel columns; `x1` must be < `WIDTH`.
- `HEIGHT`, 320: panel rows; `y1` must be < `HEIGHT`.
- `clk`  in  1  system clock, 25 MHz.
- `resetn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  one-cycle request; ignored unless idle.
- `x0`, `x1`  in  9 each  inclusive column bounds, sampled on accepted `start`.
- `y0`, `y1`  in  9 each  inclusive row bounds, sampled on accepted `start`.
- `color`  in  16  RGB565 fill value, sampled on accepted `start`.
- `busy`  out  1  high from accepted `start` through the release cycle.
- `done`  out  1  one-cycle pulse after CSX release.
- `err`  out  1  one-cycle pulse when a `start` is rejected.
- `lcd_status`  in  16  link status; bit 15 = link busy.
- `lcd_load`  out  1  byte/control strobe to link.
- `lcd_load16`  out  1  word strobe to link.
- `lcd_in`  out  16  link data: byte = {6'b0, dcx, 1'b0, byte}; release = 16'h0300.

## Operation
- States: IDLE, HDR_ISSUE, HDR_WAIT, PIX_ISSUE, PIX_WAIT, RELEASE, DONE.
- **IDLE, `start` = 1, bounds valid** (x0 ≤ x1 < WIDTH and y0 ≤ y1 < HEIGHT):
  - latch bounds and colour;
  - step index ← 0;
  - pixel count ← (x1−x0+1)·(y1−y0+1), 17-bit unsigned, max 76800;
  - go to HDR_ISSUE.
- **IDLE, `start` = 1, bounds invalid:** pulse `err`, stay IDLE, no link strobe.
- **Header steps 0–10, one byte each:**
  - 0: cmd 0x2A (dcx = 0).
  - 1–4: data x0[15:8], x0[7:0], x1[15:8], x1[7:0] (dcx = 1), with 9-bit coordinates zero-extended to 16 bits.
  - 5: cmd 0x2B.
  - 6–9: y bytes in the same order.
  - 10: cmd 0x2C.
- **HDR_ISSUE:** `lcd_load` = 1 for exactly one cycle with the step's `lcd_in`, then HDR_WAIT.
- **HDR_WAIT:** when `lcd_status[15]` = 0:
  - if step = 10, go to PIX_ISSUE;
  - otherwise step+1 and go to HDR_ISSUE.
- **PIX_ISSUE:** `lcd_load16` = 1 for one cycle, `lcd_in` = colour, then PIX_WAIT.
- **PIX_WAIT:** when link is idle, decrement count; if count reaches 0 go to RELEASE, else PIX_ISSUE.
- **RELEASE:** `lcd_load` = 1, `lcd_in` = 16'h0300 (CSX high, DCX = 1), then DONE.
- **DONE:** `done` = 1, `busy` = 0, then IDLE.
- Never assert `lcd_load` and `lcd_load16` in the same cycle.
- `start` while `busy` = 1: dropped, no `err`.
- **Reset mid-operation:**
  - all outputs return to reset values immediately;
  - the link block has no reset, so an in-flight SPI byte completes and CSX may stay low;
  - the next fill always begins with a command, so this is harmless.

## Timing
- All outputs are registered.
- Reset values: `busy` = 0, `done` = 0, `err` = 0, `lcd_load` = 0, `lcd_load16` = 0, `lcd_in` = 16'h0000.
- **Start:** `start` accepted at cycle 0 → `busy` = 1 and first `lcd_load` = 1 at cycle 1.
- **Link busy window:** `lcd_status[15]` rises the cycle after a strobe. It stays high 16 cycles (byte) or 32 cycles (word). The WAIT state observes it directly, with no settle cycle.
- **Transfer periods:**
  - next strobe 2 cycles after the link goes idle;
  - byte period = 18 cycles, word period = 34 cycles.
- **Whole fill:** first strobe at cycle 1; release strobe at cycle 1 + 11·18 + N·34; `done` on the following cycle.
- **Err:** pulse at cycle 1, one cycle wide.

## Structure
- Package `lcd_pkg`:
  - state enum;
  - command constants CASET = 8'h2A, PASET = 8'h2B, RAMWR = 8'h2C;
  - `lcd_in` encoding helpers: cmd byte, data byte, release word 16'h0300.
- Sub-module `lcd_hdr_rom`: combinational map (step[3:0], latched bounds) → `lcd_in`. Keeps the FSM free of header muxing.
- The 17-bit pixel counter lives in the top FSM module.

## Test plan
- **Single pixel.** x0 = x1 = 5, y0 = y1 = 7, colour 16'hF800.
  - Bytes 002A, 0200, 0205, 0200, 0205, 002B, 0200, 0207, 0200, 0207, 002C.
  - One `load16` with F800; release 0300; `done` at cycle 1 + 198 + 34 + 1.
- **Full screen.** 0..239 × 0..319.
  - Exactly 76800 `load16` strobes; count does not wrap; `done` once.
- **Invalid bounds.**
  - x0 = 10, x1 = 9 → `err` at cycle 1, no strobes, `busy` stays 0.
  - x1 = 240 → same response.
- **Start while busy.** Second `start` at cycle 50 with a different colour → ignored; all pixels carry the first colour.
- **Reset mid-operation.** `resetn` low during PIX_WAIT of a 4×4 fill:
  - outputs zero asynchronously;
  - after reset, a new 1×1 fill produces the full correct sequence.
- **Link model stretch.** Hold `lcd_status[15]` high 10 extra cycles on step 3 → controller waits; no strobe issued while the link is busy.
